// File: rtl/integrador_dupla_rampa_if.sv
// Switch controls from the converter FSM and integrator observables.
// master drives the switches; slave is the integrator model.
interface integrador_dupla_rampa_if #(
  parameter int VM_W = 10,
  parameter int W    = 20
);
  logic            ch_zr;
  logic            ch_vm;
  logic            ch_ref;
  logic [VM_W-1:0] vm;
  logic            Vint_z;
  logic [W-1:0]    acc;
  logic            sat;
  logic            ovr;
  logic            err;

  modport master (
    output ch_zr, ch_vm, ch_ref, vm,
    input  Vint_z, acc, sat, ovr, err
  );

  modport slave (
    input  ch_zr, ch_vm, ch_ref, vm,
    output Vint_z, acc, sat, ovr, err
  );
endinterface

// File: rtl/integrador_dupla_rampa.sv
// Cycle model of the dual-slope front end: switches, integrator and
// zero-crossing comparator feeding the converter FSM.
module integrador_dupla_rampa #(
  parameter int VM_W = 10,
  parameter int VREF = 1000,
  parameter int W    = 20
) (
  input logic                      ck,
  input logic                      rst_s,
  integrador_dupla_rampa_if.slave  bus
);
  localparam logic [W-1:0] REF = W'(VREF);
  localparam logic [W-1:0] TOP = '1;

  typedef enum logic [2:0] {
    M_HOLD, M_ZERO, M_INTEG, M_DEINT, M_ILL
  } mode_t;

  mode_t           mode;
  logic [2:0]      sw;
  logic [VM_W-1:0] vm_s;
  logic [W-1:0]    vm_x;
  logic [W:0]      sum;
  logic [W-1:0]    acc_q, acc_d;
  logic            armed_q, armed_d;
  logic            pulse_q, pulse_d;
  logic            sat_q, sat_d;
  logic            ovr_q, ovr_d;
  logic            err_q, err_d;

  assign sw   = {bus.ch_zr, bus.ch_vm, bus.ch_ref};
  assign vm_s = bus.vm;
  assign vm_x = W'(vm_s);
  assign sum  = {1'b0, acc_q} + {1'b0, vm_x};

  always_comb begin
    unique case (sw)
      3'b000:  mode = M_HOLD;
      3'b100:  mode = M_ZERO;
      3'b010:  mode = M_INTEG;
      3'b001:  mode = M_DEINT;
      default: mode = M_ILL;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    armed_d = armed_q;
    pulse_d = 1'b0;
    sat_d   = sat_q;
    ovr_d   = ovr_q;
    err_d   = err_q;
    unique case (1'b1)
      (mode == M_ZERO): begin
        acc_d   = '0;
        armed_d = 1'b0;
        sat_d   = 1'b0;
        ovr_d   = 1'b0;
      end
      (mode == M_INTEG): begin
        acc_d   = sum[W] ? TOP : sum[W-1:0];
        sat_d   = sat_q | sum[W];
        ovr_d   = ovr_q | (vm_x >= REF);
        armed_d = 1'b1;
      end
      (mode == M_DEINT): begin
        if (acc_q > REF) begin
          acc_d = acc_q - REF;
        end else begin
          // final step: one comparator pulse per armed phase
          acc_d   = '0;
          pulse_d = armed_q;
          armed_d = 1'b0;
        end
      end
      (mode == M_ILL): err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst_s) begin
      acc_q   <= '0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
      sat_q   <= 1'b0;
      ovr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      armed_q <= armed_d;
      pulse_q <= pulse_d;
      sat_q   <= sat_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
    end
  end

  assign bus.acc    = acc_q;
  assign bus.Vint_z = pulse_q;
  assign bus.sat    = sat_q;
  assign bus.ovr    = ovr_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_integrador_dupla_rampa.sv
// Bench for integrador_dupla_rampa: directed conversions plus
// random switch traffic against an arithmetic reference model.
module tb_integrador_dupla_rampa;
  localparam int VM_W = 10;
  localparam int VREF = 1000;
  localparam int W    = 20;
  localparam longint TOP = (longint'(1) << W) - 1;

  logic ck = 1'b0;
  logic rst_s;

  integrador_dupla_rampa_if #(.VM_W(VM_W), .W(W)) bus ();

  integrador_dupla_rampa #(
    .VM_W(VM_W),
    .VREF(VREF),
    .W(W)
  ) dut (
    .ck(ck),
    .rst_s(rst_s),
    .bus(bus)
  );

  always #5 ck = ~ck;

  int nvec = 0;
  int nerr = 0;

  longint m_acc;
  bit     m_armed, m_pulse, m_sat, m_ovr, m_err;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit z,
                            input bit v, input bit f,
                            input int vmv);
    int n;
    n = int'(z) + int'(v) + int'(f);
    m_pulse = 1'b0;
    if (r) begin
      m_acc = 0; m_armed = 0;
      m_sat = 0; m_ovr = 0; m_err = 0;
    end else if (n > 1) begin
      m_err = 1;
    end else if (z) begin
      m_acc = 0; m_armed = 0;
      m_sat = 0; m_ovr = 0;
    end else if (v) begin
      if (m_acc + vmv > TOP) begin
        m_acc = TOP;
        m_sat = 1;
      end else begin
        m_acc = m_acc + vmv;
      end
      if (vmv >= VREF) m_ovr = 1;
      m_armed = 1;
    end else if (f) begin
      if (m_acc > VREF) begin
        m_acc = m_acc - VREF;
      end else begin
        m_acc   = 0;
        m_pulse = m_armed;
        m_armed = 0;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit z, input bit v,
                     input bit f, input int vmv);
    rst_s      = r;
    bus.ch_zr  = z;
    bus.ch_vm  = v;
    bus.ch_ref = f;
    bus.vm     = VM_W'(vmv);
    @(posedge ck);
    model_step(r, z, v, f, vmv);
    #1;
    chk("acc", longint'(bus.acc), m_acc);
    chk("vint_z", longint'(bus.Vint_z), longint'(m_pulse));
    chk("sat", longint'(bus.sat), longint'(m_sat));
    chk("ovr", longint'(bus.ovr), longint'(m_ovr));
    chk("err", longint'(bus.err), longint'(m_err));
  endtask

  task automatic integ(input int n, input int vmv);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, vmv);
  endtask

  task automatic run_ref(input int maxe, output int first,
                         output int pulses);
    first  = 0;
    pulses = 0;
    for (int i = 1; i <= maxe; i++) begin
      cyc(0, 0, 0, 1, 0);
      if (bus.Vint_z === 1'b1) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
  endtask

  int first, pulses, sat_edge, exp_edge;
  int r, vmv, n;

  initial begin
    rst_s = 1'b1;
    bus.ch_zr = 0; bus.ch_vm = 0; bus.ch_ref = 0; bus.vm = '0;
    m_acc = 0;
    {m_armed, m_pulse, m_sat, m_ovr, m_err} = '0;

    cyc(1, 0, 0, 0, 0);
    chk("rst_acc", longint'(bus.acc), 0);
    chk("rst_vint", longint'(bus.Vint_z), 0);
    chk("rst_flags", longint'({bus.sat, bus.ovr, bus.err}), 0);

    // vm = 500
    cyc(0, 1, 0, 0, 0);
    integ(1000, 500);
    chk("int500_acc", longint'(bus.acc), 500000);
    run_ref(510, first, pulses);
    chk("p500_edge", first, 500);
    chk("p500_cnt", pulses, 1);
    chk("p500_acc", longint'(bus.acc), 0);
    chk("p500_flags", longint'({bus.sat, bus.ovr, bus.err}), 0);

    // vm = 0
    cyc(0, 1, 0, 0, 0);
    integ(1000, 0);
    chk("int0_acc", longint'(bus.acc), 0);
    run_ref(8, first, pulses);
    chk("p0_edge", first, 1);
    chk("p0_cnt", pulses, 1);

    // vm = 999, then 1000
    cyc(0, 1, 0, 0, 0);
    integ(1000, 999);
    chk("int999_acc", longint'(bus.acc), 999000);
    run_ref(1005, first, pulses);
    chk("p999_edge", first, 999);
    chk("p999_ovr", longint'(bus.ovr), 0);
    cyc(0, 1, 0, 0, 0);
    integ(1000, 1000 & 1023);
    cyc(0, 1, 0, 0, 0);
    integ(1000, 1000);
    chk("int1000_acc", longint'(bus.acc), 1000000);
    run_ref(1005, first, pulses);
    chk("p1000_edge", first, 1000);
    chk("p1000_ovr", longint'(bus.ovr), 1);
    cyc(0, 1, 0, 0, 0);
    chk("zero_ovr", longint'(bus.ovr), 0);

    // saturation with vm = 1023
    exp_edge = 1;
    while (longint'(exp_edge) * 1023 <= TOP) exp_edge++;
    sat_edge = 0;
    for (int i = 1; i <= 1100; i++) begin
      cyc(0, 0, 1, 0, 1023);
      if (bus.sat === 1'b1 && sat_edge == 0) sat_edge = i;
    end
    chk("sat_edge", sat_edge, exp_edge);
    chk("sat_acc", longint'(bus.acc), TOP);
    cyc(0, 1, 0, 0, 0);
    chk("sat_clr", longint'(bus.sat), 0);
    chk("sat_acc0", longint'(bus.acc), 0);

    // illegal switch combination
    integ(2, 617);
    chk("ill_pre", longint'(bus.acc), 1234);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 617);
      chk("ill_acc", longint'(bus.acc), 1234);
      chk("ill_vint", longint'(bus.Vint_z), 0);
      chk("ill_err", longint'(bus.err), 1);
    end
    cyc(0, 1, 0, 0, 0);
    chk("err_zero", longint'(bus.err), 1);
    cyc(1, 0, 0, 0, 0);
    chk("err_rst", longint'(bus.err), 0);

    // reset in the middle of de-integration
    cyc(0, 1, 0, 0, 0);
    integ(1000, 500);
    run_ref(199, first, pulses);
    cyc(1, 0, 0, 1, 0);
    chk("abort_acc", longint'(bus.acc), 0);
    chk("abort_vint", longint'(bus.Vint_z), 0);
    run_ref(600, first, pulses);
    chk("abort_cnt", pulses, 0);

    // random complete conversions
    for (int c = 0; c < 6; c++) begin
      vmv = $urandom_range(0, 1023);
      n   = $urandom_range(1, 1100);
      cyc(0, 1, 0, 0, 0);
      integ(n, vmv);
      run_ref(1100, first, pulses);
      chk("rconv_cnt", pulses, 1);
    end

    // random switch traffic
    for (int i = 0; i < 4000; i++) begin
      r   = $urandom_range(0, 99);
      vmv = $urandom_range(0, 1023);
      if (r < 1)       cyc(1, 0, 0, 0, vmv);
      else if (r < 4)  cyc(0, 1, 0, 0, vmv);
      else if (r < 8)  cyc(0, $urandom_range(0, 1) == 1, 1, 1, vmv);
      else if (r < 50) cyc(0, 0, 1, 0, vmv);
      else if (r < 56) cyc(0, 0, 0, 0, vmv);
      else             cyc(0, 0, 0, 1, vmv);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
